// File: rtl/tick_divider_pkg.sv
// Shared constants and helpers for the multi-channel tick divider.
package tick_divider_pkg;

  // One-second timebase from a 50 MHz board clock.
  localparam int unsigned DEFAULT_DIV_1S = 50_000_000;
  localparam int          DEFAULT_WIDTH  = 26;

  // Width of a channel-select field; never narrower than one bit.
  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel: counter, active and pending divisor, tick strobe
// and 50%-duty slow clock. Divisor changes only land on a wrap or a sync,
// so a period in flight is never cut short.
module tick_div_channel
  import tick_divider_pkg::*;
#(
  parameter int          WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_1S
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  output logic             tick,
  output logic             slowclk,
  output logic             pend_valid
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] pend_div;
  logic             at_end;

  assign at_end = (count == div - WIDTH'(1));

  // Count, wrap, apply pending divisor on wrap or sync, and capture new writes.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      div        <= WIDTH'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      tick       <= 1'b0;
      slowclk    <= 1'b0;
    end else if (sync) begin
      count      <= '0;
      tick       <= 1'b0;
      slowclk    <= 1'b0;
      pend_valid <= 1'b0;
      if (wr) begin
        div <= wr_div;
      end else if (pend_valid) begin
        div <= pend_div;
      end
    end else begin
      tick <= 1'b0;
      if (enable) begin
        if (at_end) begin
          count   <= '0;
          tick    <= 1'b1;
          slowclk <= ~slowclk;
          if (pend_valid) begin
            div        <= pend_div;
            pend_valid <= 1'b0;
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end
      // A write is only accepted while nothing is pending, so it can never
      // collide with the apply above; it waits for the following wrap.
      if (wr) begin
        pend_div   <= wr_div;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_divider.sv
// NCH independent programmable timebases. The top decodes divisor writes,
// flags invalid requests and muxes the per-channel ready status.
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter int          NCH         = 2,
  parameter int          WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_1S,
  localparam int         CW          = ch_w(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic             div_load,
  input  logic [CW-1:0]    div_ch,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ready,
  output logic             div_err,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   slowclk
);

  logic [NCH-1:0] pend_valid;
  logic [NCH-1:0] wr;
  logic           in_range;
  logic           req_ok;
  logic           accept;

  assign in_range = (int'(div_ch) < NCH);
  assign req_ok   = in_range && (div_value != '0);
  assign accept   = div_load && div_ready && req_ok;

  // Ready mux: an out-of-range channel has nothing pending, so the request
  // is presented and then rejected with an error.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    div_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (int'(div_ch) == i) div_ready = ~pend_valid[i];
    end
  end

  // Steer an accepted write to exactly one channel.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (accept && (int'(div_ch) == i)) wr[i] = 1'b1;
    end
  end

  // One-cycle error pulse for a presented but invalid write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_err <= 1'b0;
    end else begin
      div_err <= div_load && div_ready && !req_ok;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_div_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .sync       (sync),
      .wr         (wr[g]),
      .wr_div     (div_value),
      .tick       (tick[g]),
      .slowclk    (slowclk[g]),
      .pend_valid (pend_valid[g])
    );
  end

endmodule

// File: tb/tb_tick_divider.sv
// Randomized bench for tick_divider against a period-level reference model.
module tb_tick_divider;
  import tick_divider_pkg::*;

  localparam int NCH   = 3;
  localparam int WIDTH = 8;
  localparam int DEF   = 4;
  localparam int CW    = ch_w(NCH);

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             sync;
  logic             div_load;
  logic [CW-1:0]    div_ch;
  logic [WIDTH-1:0] div_value;
  logic             div_ready;
  logic             div_err;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   slowclk;

  tick_divider #(
    .NCH         (NCH),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sync      (sync),
    .div_load  (div_load),
    .div_ch    (div_ch),
    .div_value (div_value),
    .div_ready (div_ready),
    .div_err   (div_err),
    .tick      (tick),
    .slowclk   (slowclk)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel tracks enabled cycles elapsed in the
  // current period, the period length, a pending period, and how many
  // periods have completed since the last reset/sync (slowclk is its parity).
  int m_elapsed [NCH];
  int m_period  [NCH];
  int m_next    [NCH];
  int m_wraps   [NCH];
  bit m_pend    [NCH];
  bit m_tick    [NCH];
  bit m_err;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_elapsed[i] = 0;
      m_period[i]  = DEF;
      m_next[i]    = 0;
      m_wraps[i]   = 0;
      m_pend[i]    = 1'b0;
      m_tick[i]    = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit model_ready(input int ch);
    return (ch < NCH) ? !m_pend[ch] : 1'b1;
  endfunction

  function automatic void model_edge(input bit e, input bit s, input bit ld,
                                     input int ch, input int val);
    bit ready, valid, acc;
    ready = model_ready(ch);
    valid = (val != 0) && (ch < NCH);
    acc   = ld && ready && valid;
    m_err = ld && ready && !valid;
    for (int i = 0; i < NCH; i++) begin
      if (s) begin
        m_elapsed[i] = 0;
        m_wraps[i]   = 0;
        m_tick[i]    = 1'b0;
        if (acc && ch == i) m_period[i] = val;
        else if (m_pend[i]) m_period[i] = m_next[i];
        m_pend[i] = 1'b0;
      end else begin
        m_tick[i] = 1'b0;
        if (e) begin
          m_elapsed[i]++;
          if (m_elapsed[i] == m_period[i]) begin
            m_elapsed[i] = 0;
            m_tick[i]    = 1'b1;
            m_wraps[i]++;
            if (m_pend[i]) begin
              m_period[i] = m_next[i];
              m_pend[i]   = 1'b0;
            end
          end
        end
        if (acc && ch == i) begin
          m_pend[i] = 1'b1;
          m_next[i] = val;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("tick%0d", i), 32'(tick[i]), 32'(m_tick[i]));
      check($sformatf("slowclk%0d", i), 32'(slowclk[i]), 32'(m_wraps[i] % 2));
    end
    check("div_err", 32'(div_err), 32'(m_err));
  endtask

  initial begin
    int first_edge;
    int gap;
    reset     = 1'b0;
    enable    = 1'b0;
    sync      = 1'b0;
    div_load  = 1'b0;
    div_ch    = '0;
    div_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_slowclk", 32'(slowclk), 32'd0);
    check("reset_div_err", 32'(div_err), 32'd0);
    check("reset_div_ready", 32'(div_ready), 32'd1);

    // First tick latency and repeat period at the reset divisor.
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    first_edge = 0;
    for (int n = 1; n <= 20 && first_edge == 0; n++) begin
      @(posedge clk);
      #1;
      if (tick[0]) first_edge = n;
    end
    check("first_tick_edge", 32'(first_edge), 32'(DEF));
    check("first_slowclk", 32'(slowclk), {{(32-NCH){1'b0}}, {NCH{1'b1}}});
    gap = 0;
    for (int n = 1; n <= 20 && gap == 0; n++) begin
      @(posedge clk);
      #1;
      if (tick[0]) gap = n;
    end
    check("tick_period", 32'(gap), 32'(DEF));
    check("second_slowclk", 32'(slowclk), 32'd0);

    // Randomized phase; async reset pulses are scattered through it.
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    model_reset();
    for (int it = 0; it < 4000; it++) begin
      @(negedge clk);
      reset = 1'b1;
      check_outputs();
      enable    = ($urandom_range(0, 9) != 0);
      sync      = ($urandom_range(0, 39) == 0);
      div_load  = ($urandom_range(0, 3) == 0);
      div_ch    = CW'($urandom_range(0, 3));
      div_value = WIDTH'($urandom_range(0, 6));
      #1;
      check("div_ready", 32'(div_ready), 32'(model_ready(int'(div_ch))));
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #1;
        check("async_tick", 32'(tick), 32'd0);
        check("async_slowclk", 32'(slowclk), 32'd0);
        check("async_div_err", 32'(div_err), 32'd0);
        check("async_div_ready", 32'(div_ready), 32'd1);
        model_reset();
      end else begin
        model_edge(enable, sync, div_load, int'(div_ch), int'(div_value));
      end
    end
    @(negedge clk);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_divider.md
# tick_divider

Parametrised, multi-channel successor to the single fixed clock divider. Generates NCH independent, runtime-programmable timebases from the system clock. Each channel provides two outputs: a one-cycle `tick` strobe and a 50%-duty `slowclk` square wave. Sits between the board clock and the traffic-light sequencer, which uses the ticks for phase timing (e.g. 1 s main phase, faster pedestrian blink).

## Interface
Parameters:
- `NCH`, 2: number of divider channels (1..8).
- `WIDTH`, 26: divisor/counter width in bits.
- `DEFAULT_DIV`, 50_000_000: divisor loaded into every channel at reset; must be in 1..2^WIDTH-1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global count enable; low freezes all channels.
- `sync`  in  1  synchronous restart of all channels.
- `div_load`  in  1  divisor write request.
- `div_ch`  in  $clog2(NCH) (min 1)  target channel of the write.
- `div_value`  in  WIDTH  new divisor D.
- `div_ready`  out  1  combinational; high when channel `div_ch` has no pending update.
- `div_err`  out  1  registered one-cycle pulse; a write was rejected.
- `tick`  out  NCH  registered one-cycle strobe per channel.
- `slowclk`  out  NCH  registered square wave per channel; period 2·D cycles.

## Operation
- Per-channel state: `count[WIDTH]`, `div[WIDTH]`, `pend_div[WIDTH]`, `pend_valid`, `tick`, `slowclk`.
- Reset values: count=0, div=DEFAULT_DIV, pend_valid=0, tick=0, slowclk=0, div_err=0.
- Counting, when enable=1 and sync=0:
  - If count==div-1, count wraps to 0, `tick` is set for the next cycle, and `slowclk` toggles.
  - Otherwise count increments and tick=0.
- enable=0: count, div and slowclk hold. tick=0.
- D=1: a tick every enabled cycle; slowclk = clk/2.
- Write handshake:
  - A write is accepted when div_load=1, div_ready=1, div_value≠0 and div_ch<NCH. It sets pend_valid and pend_div for that channel.
  - div_value=0 or div_ch≥NCH is rejected: div_err pulses next cycle and no state changes.
  - div_load with div_ready=0 is ignored silently. The requester must hold div_load until it sees ready; no error is raised.
- Apply rule (glitch-free):
  - A pending divisor takes effect at that channel's next wrap: div←pend_div, pend_valid←0.
  - The tick for that wrap still issues, so the old period completes intact.
  - A write accepted in the same cycle as a wrap is applied at the following wrap, never the current one.
- sync=1 (overrides enable):
  - All counts←0, slowclk←0, tick←0.
  - Any pending divisor is applied immediately. A write accepted in the same cycle is also applied immediately.
- Asynchronous reset mid-operation: all state returns to reset values immediately; pending writes are lost.

## Timing
- Latency: with enable held high from reset release, the first tick is high during cycle D+1. It asserts after the D-th rising edge and lasts exactly one cycle. Ticks then recur every D cycles.
- slowclk rises on the same edge as the first tick.
- Write to effect: new period begins at the first wrap ≥1 cycle after acceptance. Worst case is old D + 1 cycles.
- div_ready drops the cycle after acceptance and returns high the cycle after the apply edge.
- div_err follows the rejected request by exactly 1 cycle.
- No combinational path from inputs to tick, slowclk or div_err.

## Structure
- Package `tick_divider_pkg`: `DEFAULT_DIV_1S` (50_000_000), `DEFAULT_WIDTH` (26), and a channel-index width helper.
- Sub-module `tick_div_channel` (count/div/pending/tick/slowclk for one channel), instantiated NCH times in a generate loop.
- Top level: write decode, error generation, div_ready mux.

## Test plan
- Reset release with NCH=2, DEFAULT_DIV=4, enable=1 -> both ticks in cycles 5, 9, 13; slowclk toggles on those edges (period 8).
- Load ch1 D=3 at cycle 2 -> div_ready low from cycle 3; ch1 wraps at old period (tick cycle 5), then ticks at 8, 11. ch0 is unaffected.
- Loads with div_value=0 and with div_ch=2 (NCH=2) -> div_err one-cycle pulse each; ticks unchanged.
- enable low for 10 cycles mid-period at count=2 -> no ticks; count resumes from 2; next tick 2 cycles after enable returns (D=4).
- sync together with a load of D=2 on ch0 -> counts 0, slowclk 0; ch0 ticks 2 cycles later, every 2 cycles after.
- reset asserted while ch0 has a pending write -> outputs 0 immediately; after release ch0 runs at DEFAULT_DIV and div_ready=1.
